// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register file and streams each register out as a valid/ready beat
module regfile_dump_reader #(
    parameter int P_WIDTH     = 16,
    parameter int P_NUM_REGS  = 16,
    parameter int P_SEL_WIDTH = 4
) (
    input  logic                   I_CLK,
    input  logic                   I_NRESET,
    input  logic                   I_START,
    input  logic                   I_ABORT,
    output logic [P_SEL_WIDTH-1:0] O_REG_SEL,
    input  logic [P_WIDTH-1:0]     I_REG_DATA,
    output logic [P_WIDTH-1:0]     O_DATA,
    output logic [P_SEL_WIDTH-1:0] O_INDEX,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic                   O_BUSY,
    output logic                   O_DONE
);

    // P_NUM_REGS must fit in P_SEL_WIDTH bits; the last index is the wrap point
    localparam logic [P_SEL_WIDTH-1:0] LAST_IDX = P_SEL_WIDTH'(P_NUM_REGS - 1);
    localparam logic [P_SEL_WIDTH-1:0] IDX_ONE  = {{(P_SEL_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [P_SEL_WIDTH-1:0]  idx_q;
    logic [P_SEL_WIDTH-1:0]  idx_d;
    logic [P_WIDTH-1:0]      data_q;
    logic [P_SEL_WIDTH-1:0]  index_q;
    logic                    capture;

    // State and index registers; reset clears everything without a clock edge
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Beat holding registers: loaded only in FETCH so they hold through PRESENT, DONE and IDLE
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            data_q  <= '0;
            index_q <= '0;
        end else if (capture) begin
            data_q  <= I_REG_DATA;
            index_q <= idx_q;
        end
    end

    // Next-state logic; abort wins over ready and start in every state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // start only launches a dump when abort is not also asserted
                if (I_START && !I_ABORT) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (I_ABORT) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    capture = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (I_ABORT) begin
                    // a beat accepted together with abort is the final one
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (I_READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from registered state so they drop the instant reset asserts
    always_comb begin
        O_REG_SEL = idx_q;
        O_DATA    = data_q;
        O_INDEX   = index_q;
        O_VALID   = (state_q == PRESENT);
        O_BUSY    = (state_q != IDLE);
        O_DONE    = (state_q == DONE);
    end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 Parameter P_WIDTH, default 16, SHALL set the register data width.
REQ-002 Parameter P_NUM_REGS, default 16, SHALL set the number of registers read per dump.
REQ-003 Parameter P_SEL_WIDTH, default 4, SHALL set the select/index width; P_NUM_REGS SHALL be at most 2**P_SEL_WIDTH.
REQ-004 I_CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 I_NRESET  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 I_START  in  1  SHALL request a dump; it is sampled only in IDLE.
REQ-007 I_ABORT  in  1  SHALL cancel a dump in progress.
REQ-008 O_REG_SEL  out  P_SEL_WIDTH  SHALL be the register-file read select.
REQ-009 I_REG_DATA  in  P_WIDTH  SHALL be the register-file combinational read data for O_REG_SEL.
REQ-010 O_DATA  out  P_WIDTH  SHALL be the captured register value presented downstream.
REQ-011 O_INDEX  out  P_SEL_WIDTH  SHALL be the register number of O_DATA.
REQ-012 O_VALID  out  1  SHALL indicate that O_DATA/O_INDEX hold a beat.
REQ-013 I_READY  in  1  SHALL indicate downstream acceptance.
REQ-014 O_BUSY  out  1  SHALL be high in every state except IDLE.
REQ-015 O_DONE  out  1  SHALL pulse high for one cycle when a dump completes.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FETCH, PRESENT, DONE.
REQ-017 IDLE with I_START=1 SHALL go to FETCH with the index counter at 0; otherwise SHALL remain in IDLE.
REQ-018 O_REG_SEL SHALL equal the index counter in all states.
REQ-019 FETCH SHALL capture I_REG_DATA into O_DATA and the index into O_INDEX, then go to PRESENT, always after exactly one cycle.
REQ-020 O_VALID SHALL be high exactly when the state is PRESENT.
REQ-021 In PRESENT with I_READY=0, O_DATA, O_INDEX and O_VALID SHALL hold unchanged.
REQ-022 A beat SHALL be accepted on any rising edge where O_VALID=1 and I_READY=1.
REQ-023 On acceptance with index < P_NUM_REGS-1, the index SHALL increment by 1 and the FSM SHALL go to FETCH.
REQ-024 On acceptance with index = P_NUM_REGS-1, the FSM SHALL go to DONE and the index SHALL reset to 0; the index SHALL never wrap past P_NUM_REGS-1.
REQ-025 DONE SHALL assert O_DONE for one cycle, then go to IDLE unconditionally.
REQ-026 Latency: with I_START sampled at edge t, FETCH SHALL occupy cycle t+1 and O_VALID SHALL first be high in cycle t+2.
REQ-027 With I_READY held high, beat k SHALL be valid in cycle t+2+2k; O_DONE SHALL be high in cycle t+2*P_NUM_REGS+1.
REQ-028 I_START outside IDLE SHALL be ignored, with no queuing.
REQ-029 I_ABORT=1 in FETCH, PRESENT or DONE SHALL force IDLE at the next edge with the index at 0 and O_VALID low; O_DONE SHALL not pulse for an aborted dump.
REQ-030 I_ABORT and I_READY both high in PRESENT SHALL resolve in favour of abort; the beat counts as accepted, with no further beat.
REQ-031 I_ABORT and I_START both high in IDLE SHALL leave the FSM in IDLE.
REQ-032 O_DATA and O_INDEX SHALL retain their last values in IDLE and DONE.

Reset
REQ-033 I_NRESET=0 SHALL immediately, without waiting for a clock edge, force IDLE, index 0, O_DATA 0, O_INDEX 0, O_VALID 0, O_BUSY 0 and O_DONE 0.
REQ-034 Reset asserted mid-dump SHALL discard the dump; after release, the FSM SHALL wait in IDLE for a new I_START.

Verification
REQ-035 Registers preloaded with r[i]=0x1000+i, I_READY=1, START pulse at edge t -> 16 beats (index i, data 0x1000+i) valid in cycles t+2+2i; O_DONE high only in cycle t+33.
REQ-036 I_READY low for 3 cycles while beat 5 is valid -> O_DATA=0x1005 and O_INDEX=5 held stable for 4 cycles; beat 6 follows normally.
REQ-037 I_ABORT at the beat-7 acceptance edge -> IDLE next cycle, O_VALID=0, no O_DONE; a new START replays from index 0.
REQ-038 I_NRESET pulled low between clock edges during beat 3 -> all outputs 0 immediately; no activity until the next I_START.
REQ-039 I_START pulsed repeatedly during a dump -> exactly 16 beats and exactly one O_DONE.
REQ-040 P_NUM_REGS=8, back-to-back START immediately after DONE -> two dumps of 8 beats, each with index 0..7 and no skipped or duplicated beat.
